comm_sut_seq: RTL and testbench

COMM_SUT_SEQ -- requirements
Module: comm_sut_seq

---
 rtl/comm_seq_pkg.sv | 23 ++
 rtl/comm_strobe_gen.sv | 58 +++++
 rtl/comm_sut_seq.sv | 122 ++++++++++++
 tb/tb_comm_sut_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/comm_seq_pkg.sv
// Shared types and constants for the SUT measurement sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package comm_seq_pkg;

  localparam int         SAM_PER_SYM = 4;     // samples per symbol
  localparam logic [2:0] DLY_SEL_MAX = 3'd4;  // highest receive-delay tap
  localparam int         SYM_CNT_W   = 16;    // width of the window symbol counter

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CLEAR  = 3'd2,
    ACCUM  = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  // Clamp a manual delay select to the valid tap range.
  function automatic logic [2:0] sat_dly(input logic [2:0] d);
    return (d > DLY_SEL_MAX) ? DLY_SEL_MAX : d;
  endfunction

endpackage

// File: rtl/comm_strobe_gen.sv
// Free-running sample/symbol strobe generator with boundary-safe phase select.
// Latency: strobes registered; first sam_clk on the CLK_PER_SAM-th cycle after reset.
// Backpressure: none, runs unconditionally.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   sym_phase [1:0]     - sample slot within the symbol that carries sym_clk
//   sam_clk             - one-cycle pulse every CLK_PER_SAM cycles
//   sym_clk             - one-cycle pulse coincident with the selected sam_clk
//   sym_bnd             - one-cycle pulse with the last sam_clk of each symbol
module comm_strobe_gen
  import comm_seq_pkg::*;
#(
  parameter int CLK_PER_SAM = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sym_phase,
  output logic       sam_clk,
  output logic       sym_clk,
  output logic       sym_bnd
);

  localparam int               CNT_W    = $clog2(CLK_PER_SAM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SAM - 1);
  localparam logic [1:0]       SAM_LAST = 2'(SAM_PER_SYM - 1);

  logic [CNT_W-1:0] clk_cnt;
  logic [1:0]       sam_cnt;  // index of the sample strobed at the next wrap
  logic [1:0]       phase;    // latched sym_phase, only updated at symbol boundary
  logic             wrap;

  assign wrap = (clk_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt <= '0;
      sam_cnt <= '0;
      phase   <= '0;
      sam_clk <= 1'b0;
      sym_clk <= 1'b0;
      sym_bnd <= 1'b0;
    end else begin
      clk_cnt <= wrap ? '0 : clk_cnt + 1'b1;
      sam_clk <= wrap;
      sym_clk <= wrap && (sam_cnt == phase);
      sym_bnd <= wrap && (sam_cnt == SAM_LAST);
      if (wrap) begin
        sam_cnt <= sam_cnt + 2'd1;
        // Taking the new phase only after the last sample of a group keeps
        // exactly one sym_clk per group, whatever the old and new slots are.
        if (sam_cnt == SAM_LAST)
          phase <= sym_phase;
      end
    end
  end

endmodule

// File: rtl/comm_sut_seq.sv
// Measurement sequencer: settle, clear, accumulate a symbol window, report done.
// Latency: all outputs registered; FSM reacts one cycle after start/abort/sym_clk.
// Backpressure: none; start ignored while busy, abort always wins.
//
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   start, abort          - measurement request pulse / cancel
//   sym_phase [1:0]       - sym_clk sample slot (taken at symbol boundaries)
//   dly_sel_in [2:0]      - manual receive-delay select (saturated to 4)
//   sam_clk, sym_clk      - free-running strobes
//   clear_accum, accum_en - accumulator controls for the SUT datapath
//   meas_done, busy       - one-cycle completion pulse / sequence active
//   dly_sel [2:0]         - delay select driving the SUT receive-delay mux
//   sym_count [15:0]      - symbols accumulated in the current window
// Build option SEQ_DLY_SWEEP_EN: one start sweeps dly_sel 0..4, one window each.
module comm_sut_seq
  import comm_seq_pkg::*;
#(
  parameter int CLK_PER_SAM = 4,
  parameter int SETTLE_SYMS = 16,
  parameter int ACC_SYMS    = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           sym_phase,
  input  logic [2:0]           dly_sel_in,
  output logic                 sam_clk,
  output logic                 sym_clk,
  output logic                 clear_accum,
  output logic                 accum_en,
  output logic                 meas_done,
  output logic                 busy,
  output logic [2:0]           dly_sel,
  output logic [SYM_CNT_W-1:0] sym_count
);

  localparam logic [11:0]          SETTLE_LAST = 12'(SETTLE_SYMS - 1);
  localparam logic [SYM_CNT_W-1:0] ACC_LAST    = SYM_CNT_W'(ACC_SYMS - 1);

  seq_state_t  state, nxt;
  logic [11:0] settle_cnt;
  logic        sym_bnd_unused;  // boundary flag is for datapath taps, not the FSM

  comm_strobe_gen #(
    .CLK_PER_SAM (CLK_PER_SAM)
  ) u_strobe (
    .clk       (clk),
    .reset     (reset),
    .sym_phase (sym_phase),
    .sam_clk   (sam_clk),
    .sym_clk   (sym_clk),
    .sym_bnd   (sym_bnd_unused)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = SETTLE;
      SETTLE:  if (sym_clk && settle_cnt == SETTLE_LAST) nxt = CLEAR;
      CLEAR:   if (sym_clk) nxt = ACCUM;
      ACCUM:   if (sym_clk && sym_count == ACC_LAST) nxt = DONE;
`ifdef SEQ_DLY_SWEEP_EN
      DONE:    nxt = (dly_sel < DLY_SEL_MAX) ? SETTLE : IDLE;
`else
      DONE:    nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
    // abort overrides everything, including a start seen in IDLE
    if (abort) nxt = IDLE;
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe without any input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      sym_count   <= '0;
      clear_accum <= 1'b0;
      accum_en    <= 1'b0;
      meas_done   <= 1'b0;
      busy        <= 1'b0;
      dly_sel     <= '0;
    end else begin
      state       <= nxt;
      busy        <= (nxt != IDLE);
      clear_accum <= (nxt == CLEAR);
      accum_en    <= (nxt == ACCUM);
      meas_done   <= (nxt == DONE);

      if (state != SETTLE)
        settle_cnt <= '0;
      else if (sym_clk)
        settle_cnt <= settle_cnt + 12'd1;

      // Final count is held through DONE/IDLE until the next window clears it.
      if (nxt == CLEAR && state != CLEAR)
        sym_count <= '0;
      else if (state == ACCUM && sym_clk && !abort)
        sym_count <= sym_count + 1'b1;

`ifdef SEQ_DLY_SWEEP_EN
      if (state == IDLE && nxt == SETTLE)
        dly_sel <= '0;
      else if (state == DONE && !abort && dly_sel < DLY_SEL_MAX)
        dly_sel <= dly_sel + 3'd1;
`else
      dly_sel <= sat_dly(dly_sel_in);
`endif
    end
  end

`ifdef SEQ_DLY_SWEEP_EN
  // Manual select has no effect while the sweep owns dly_sel.
  logic dly_sel_in_unused;
  assign dly_sel_in_unused = ^dly_sel_in;
`endif

endmodule

// File: tb/tb_comm_sut_seq.sv
// Directed bench for comm_sut_seq (CLK_PER_SAM=4, SETTLE_SYMS=2, ACC_SYMS=5).
// Latency: n/a.
// Backpressure: n/a.
module tb_comm_sut_seq;

  logic        clk, reset, start, abort;
  logic [1:0]  sym_phase;
  logic [2:0]  dly_sel_in;
  logic        sam_clk, sym_clk, clear_accum, accum_en, meas_done, busy;
  logic [2:0]  dly_sel;
  logic [15:0] sym_count;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

`ifdef SEQ_DLY_SWEEP_EN
  localparam int LAST = 95;
`else
  localparam int LAST = 360;
`endif

  comm_sut_seq #(
    .CLK_PER_SAM (4),
    .SETTLE_SYMS (2),
    .ACC_SYMS    (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .sym_phase   (sym_phase),
    .dly_sel_in  (dly_sel_in),
    .sam_clk     (sam_clk),
    .sym_clk     (sym_clk),
    .clear_accum (clear_accum),
    .accum_en    (accum_en),
    .meas_done   (meas_done),
    .busy        (busy),
    .dly_sel     (dly_sel),
    .sym_count   (sym_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Hand-derived timeline (cycle 0 = first cycle after reset release):
  // phase 0 -> sym_clk at 3,19,35; sym_phase=2 from cycle 41, latched at the
  // boundary strobe of cycle 47 -> sym_clk at 59,75,... (c%16==11).
  function automatic logic exp_sym(input int c);
    return (c < 48) ? (c % 16 == 3) : (c % 16 == 11);
  endfunction

  // start@96 -> SETTLE 97; syms 107,123 -> CLEAR 124..139; sym 139 -> ACCUM
  // 140..219 (syms 155..219); DONE 220; IDLE 221. start@150 ignored.
  // start@240 -> SETTLE 241; CLEAR 268..283; ACCUM 284..; abort@331 -> IDLE 332.
  function automatic logic exp_busy(input int c);
    return (c >= 97 && c <= 220) || (c >= 241 && c <= 331);
  endfunction
  function automatic logic exp_clr(input int c);
    return (c >= 124 && c <= 139) || (c >= 268 && c <= 283);
  endfunction
  function automatic logic exp_acc(input int c);
    return (c >= 140 && c <= 219) || (c >= 284 && c <= 331);
  endfunction
  function automatic int exp_cnt(input int c);
    if (c < 156) return 0;
    if (c < 172) return 1;
    if (c < 188) return 2;
    if (c < 204) return 3;
    if (c < 220) return 4;
    if (c < 268) return 5;
    if (c < 300) return 0;
    if (c < 316) return 1;
    return 2;
  endfunction

  initial begin
    bit found;
    int npulse;

    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    sym_phase  = 2'd0;
    dly_sel_in = 3'd0;
    repeat (3) tick();

    check("rst_sam_clk",   sam_clk,     0);
    check("rst_sym_clk",   sym_clk,     0);
    check("rst_clear",     clear_accum, 0);
    check("rst_accum_en",  accum_en,    0);
    check("rst_meas_done", meas_done,   0);
    check("rst_busy",      busy,        0);
    check("rst_dly_sel",   dly_sel,     0);
    check("rst_sym_count", sym_count,   0);

    reset = 1'b0;
    cyc   = -1;
    for (int c = 0; c <= LAST; c++) begin
      tick();
      sym_phase = (c >= 41) ? 2'd2 : 2'd0;
`ifndef SEQ_DLY_SWEEP_EN
      start = (c == 96) || (c == 150) || (c == 240) || (c == 340);
      abort = (c == 331) || (c == 340);
`endif
      check("sam_clk", sam_clk, (c % 4 == 3));
      check("sym_clk", sym_clk, exp_sym(c));
`ifndef SEQ_DLY_SWEEP_EN
      check("busy",        busy,        exp_busy(c));
      check("clear_accum", clear_accum, exp_clr(c));
      check("accum_en",    accum_en,    exp_acc(c));
      check("meas_done",   meas_done,   (c == 220));
      check("sym_count",   sym_count,   exp_cnt(c));
      check("dly_sel",     dly_sel,     0);
`endif
    end
    start = 1'b0;
    abort = 1'b0;

`ifdef SEQ_DLY_SWEEP_EN
    start = 1'b1;
    tick();
    start  = 1'b0;
    npulse = 0;
    for (int k = 0; k < 2000; k++) begin
      if (meas_done) begin
        check("sweep_dly_at_done", dly_sel, npulse);
        npulse++;
      end
      if (!busy) break;
      tick();
    end
    check("sweep_pulses",    npulse,  5);
    check("sweep_final_dly", dly_sel, 4);
    check("sweep_busy_end",  busy,    0);
`else
    dly_sel_in = 3'd7;
    check("dly_no_comb", dly_sel, 0);
    tick();
    check("dly_sat_7", dly_sel, 4);
    dly_sel_in = 3'd3;
    tick();
    check("dly_pass_3", dly_sel, 3);
    dly_sel_in = 3'd0;
    tick();
    check("dly_pass_0", dly_sel, 0);
`endif

    // Reset in the middle of an accumulate window.
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (accum_en && sym_count == 16'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reach_accum", found, 1);
    reset = 1'b1;
    tick();
    check("mr_sam_clk",   sam_clk,     0);
    check("mr_sym_clk",   sym_clk,     0);
    check("mr_clear",     clear_accum, 0);
    check("mr_accum_en",  accum_en,    0);
    check("mr_meas_done", meas_done,   0);
    check("mr_busy",      busy,        0);
    check("mr_dly_sel",   dly_sel,     0);
    check("mr_sym_count", sym_count,   0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_sam_clk", sam_clk, (k == 3));
      check("post_rst_sym_clk", sym_clk, (k == 3));
      check("post_rst_busy",    busy,    0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
